i2c_codec_target: RTL and testbench

// - I2C write-only target (responder) modelling the SSM2603 codec control port; the far end of the codec I2C config master.
// - Decodes 3-byte writes {dev_addr+W, hi, lo}. ACKs each byte and commits the 16-bit word {reg[6:0], data[8:0]} to a register file.
// - Used as a synthesizable codec stand-in for board bring-up and simulation. Also gives a debug readback of the programmed codec state.
//

---
 rtl/codec_i2c_pkg.sv | 42 ++++
 rtl/i2c_bus_sync.sv | 47 ++++
 rtl/i2c_codec_target.sv | 184 ++++++++++++++++++
 tb/tb_i2c_codec_target.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_i2c_pkg.sv
// Shared definitions for the SSM2603 codec control-port target: FSM states,
// the codec's I2C address, register indices and the decoded word layout.
package codec_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_HI,
        ST_ACK_HI,
        ST_LO,
        ST_ACK_LO,
        ST_IGNORE
    } i2c_state_t;

    localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;

    localparam logic [6:0] R_LIN     = 7'd0;
    localparam logic [6:0] R_RIN     = 7'd1;
    localparam logic [6:0] R_LOUT    = 7'd2;
    localparam logic [6:0] R_ROUT    = 7'd3;
    localparam logic [6:0] R_AAPATH  = 7'd4;
    localparam logic [6:0] R_DAPATH  = 7'd5;
    localparam logic [6:0] R_POWER   = 7'd6;
    localparam logic [6:0] R_DAIF    = 7'd7;
    localparam logic [6:0] R_SRATE   = 7'd8;
    localparam logic [6:0] R_ACTIVE  = 7'd9;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } codec_word_t;

    // The codec packs a 7-bit register index and 9-bit value into two bytes.
    function automatic codec_word_t decode_word(input logic [7:0] hi, input logic [7:0] lo);
        codec_word_t w;
        w.addr = hi[7:1];
        w.data = {hi[0], lo};
        return w;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives the bit-timing strobes
// (SCL rise/fall) and bus-condition strobes (START/STOP) from them.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_pipe;
    logic [SYNC_STAGES-1:0] r_sda_pipe;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Synchronizer chains plus one delayed copy for edge detection; idle bus reads high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_pipe <= '1;
            r_sda_pipe <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_pipe <= {r_scl_pipe[SYNC_STAGES-2:0], i_scl};
            r_sda_pipe <= {r_sda_pipe[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_pipe[SYNC_STAGES-1];
    assign w_sda      = r_sda_pipe[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign o_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target standing in for the SSM2603 control port. Accepts
// {dev_addr+W, hi, lo} writes, ACKs each byte, commits the 16-bit word to a
// register file and exposes a combinational debug readback.
module i2c_codec_target
    import codec_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = CODEC_DEV_ADDR,
    parameter logic [6:0] LAST_REG    = 7'h12,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_i2c_sclk,
    inout  wire        io_i2c_sdat,
    output logic       o_reg_wr_valid,
    output logic [6:0] o_reg_wr_addr,
    output logic [8:0] o_reg_wr_data,
    input  logic [6:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic       o_aborted
);

    localparam int IDX_W     = $clog2(int'(LAST_REG) + 1);
    localparam int REG_DEPTH = 1 << IDX_W;

    i2c_state_t  r_state;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_done;
    logic [7:0]  r_shift;
    logic [7:0]  r_hi;
    logic        r_sda_oe;
    logic        r_busy;
    logic        r_aborted;
    logic        r_wr_valid;
    codec_word_t r_wr_word;
    logic [8:0]  r_regs [0:REG_DEPTH-1];

    logic        w_sda;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_receiving;
    logic        w_in_word;
    logic        w_commit;
    codec_word_t w_word;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (i_i2c_sclk),
        .i_sda      (io_i2c_sdat),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // Open-drain: only ever pull low or let go.
    assign io_i2c_sdat = r_sda_oe ? 1'b0 : 1'bz;

    assign w_receiving = (r_state == ST_ADDR) || (r_state == ST_HI) || (r_state == ST_LO);
    assign w_in_word   = (r_state == ST_HI) || (r_state == ST_ACK_HI) || (r_state == ST_LO);
    assign w_commit    = (r_state == ST_ACK_LO) && w_scl_fall;
    assign w_word      = decode_word(r_hi, r_shift);

    // Protocol FSM: bus conditions override bit handling; bits shift on SCL rise, SDA drive changes on SCL fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_shift     <= '0;
            r_hi        <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_aborted   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_word   <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            r_aborted  <= 1'b0;
            if (w_start) begin
                r_aborted   <= w_in_word;
                r_state     <= ST_ADDR;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b1;
            end else if (w_stop) begin
                r_aborted   <= w_in_word;
                r_state     <= ST_IDLE;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                if (w_scl_rise && w_receiving) begin
                    r_shift   <= {r_shift[6:0], w_sda};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_done <= 1'b1;
                    end
                end
                if (w_scl_fall) begin
                    case (r_state)
                        ST_ADDR: begin
                            if (r_byte_done) begin
                                r_byte_done <= 1'b0;
                                if (r_shift == {DEV_ADDR, 1'b0}) begin
                                    r_sda_oe <= 1'b1;
                                    r_state  <= ST_ACK_ADDR;
                                end else begin
                                    r_state  <= ST_IGNORE;
                                end
                            end
                        end
                        ST_ACK_ADDR: begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_HI;
                        end
                        ST_HI: begin
                            if (r_byte_done) begin
                                r_byte_done <= 1'b0;
                                r_hi        <= r_shift;
                                r_sda_oe    <= 1'b1;
                                r_state     <= ST_ACK_HI;
                            end
                        end
                        ST_ACK_HI: begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_LO;
                        end
                        ST_LO: begin
                            if (r_byte_done) begin
                                r_byte_done <= 1'b0;
                                r_sda_oe    <= 1'b1;
                                r_state     <= ST_ACK_LO;
                            end
                        end
                        ST_ACK_LO: begin
                            r_sda_oe   <= 1'b0;
                            r_wr_valid <= 1'b1;
                            r_wr_word  <= w_word;
                            r_state    <= ST_IGNORE;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Register file: written alongside the commit pulse; out-of-range indices are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && (w_word.addr <= LAST_REG)) begin
            r_regs[w_word.addr[IDX_W-1:0]] <= w_word.data;
        end
    end

    // Debug readback; indices past the last implemented register read as zero.
    always_comb begin
        o_rd_data = '0;
        if (i_rd_addr <= LAST_REG) begin
            o_rd_data = r_regs[i_rd_addr[IDX_W-1:0]];
        end
    end

    assign o_reg_wr_valid = r_wr_valid;
    assign o_reg_wr_addr  = r_wr_word.addr;
    assign o_reg_wr_data  = r_wr_word.data;
    assign o_busy         = r_busy;
    assign o_aborted      = r_aborted;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for the codec I2C target: a bit-banged master drives SCL/SDA
// with a quarter-bit of 5 clk, and monitors count commits, aborts and SDA pulls.
`timescale 1ns/1ps
module tb_i2c_codec_target;
    import codec_i2c_pkg::*;

    localparam int QTR = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_m_scl;
    logic       r_m_low;
    logic [6:0] r_rd_addr;
    wire        w_sda;
    logic       w_valid;
    logic [6:0] w_wr_addr;
    logic [8:0] w_wr_data;
    logic [8:0] w_rd_data;
    logic       w_busy;
    logic       w_aborted;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int abort_cnt = 0;
    int dut_low_cnt = 0;
    logic [6:0] last_addr = '0;
    logic [8:0] last_data = '0;

    assign w_sda = r_m_low ? 1'b0 : 1'bz;
    pullup (w_sda);

    // Free-running 100 MHz system clock.
    always #5 clk = ~clk;

    i2c_codec_target #(
        .DEV_ADDR    (CODEC_DEV_ADDR),
        .LAST_REG    (7'h12),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_i2c_sclk     (r_m_scl),
        .io_i2c_sdat    (w_sda),
        .o_reg_wr_valid (w_valid),
        .o_reg_wr_addr  (w_wr_addr),
        .o_reg_wr_data  (w_wr_data),
        .i_rd_addr      (r_rd_addr),
        .o_rd_data      (w_rd_data),
        .o_busy         (w_busy),
        .o_aborted      (w_aborted)
    );

    // Record every commit and abort pulse, and every cycle the target pulls SDA while the master has let go.
    always @(negedge clk) begin
        if (w_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            last_addr <= w_wr_addr;
            last_data <= w_wr_data;
        end
        if (w_aborted === 1'b1) abort_cnt <= abort_cnt + 1;
        if (!r_m_low && w_sda === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
    end

    task automatic wait_q();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic bus_start();
        r_m_low = 1'b0;
        wait_q();
        r_m_scl = 1'b1;
        wait_q();
        r_m_low = 1'b1;
        wait_q();
        r_m_scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        r_m_low = 1'b1;
        wait_q();
        r_m_scl = 1'b1;
        wait_q();
        r_m_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            r_m_low = ~b[i];
            wait_q();
            r_m_scl = 1'b1;
            wait_q();
            wait_q();
            r_m_scl = 1'b0;
            wait_q();
        end
    endtask

    task automatic ack_phase(output logic ack);
        r_m_low = 1'b0;
        wait_q();
        r_m_scl = 1'b1;
        wait_q();
        ack = (w_sda === 1'b0);
        wait_q();
        r_m_scl = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_phase(ack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r_m_scl = 1'b1;
        r_m_low = 1'b0;
        r_rd_addr = 7'd6;
        repeat (3) @(negedge clk);
        checks++; if (w_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", w_busy); end
        checks++; if (w_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", w_valid); end
        checks++; if (w_wr_addr !== 7'd0 || w_wr_data !== 9'd0) begin errors++; $display("[TB] FAIL reset_wr_word: got %h/%h expected 00/000", w_wr_addr, w_wr_data); end
        checks++; if (w_aborted !== 1'b0) begin errors++; $display("[TB] FAIL reset_aborted: got %0b expected 0", w_aborted); end
        checks++; if (w_sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", w_sda); end
        checks++; if (w_rd_data !== 9'd0) begin errors++; $display("[TB] FAIL reset_rd: got %h expected 000", w_rd_data); end
        rst_n = 1'b1;
        wait_q();
        checks++; if (w_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %0b expected 0", w_busy); end
    endtask

    task automatic test_basic_write();
        int   bv;
        int   ba;
        logic a0, a1, a2;
        bv = valid_cnt;
        ba = abort_cnt;
        bus_start();
        checks++; if (w_busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start: got %0b expected 1", w_busy); end
        send_byte(8'h34, a0);
        send_byte(8'h0C, a1);
        send_byte(8'h10, a2);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("[TB] FAIL basic_acks: got %b expected 111", {a0, a1, a2}); end
        bus_stop();
        checks++; if (valid_cnt - bv !== 1) begin errors++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", valid_cnt - bv); end
        checks++; if (last_addr !== 7'h06 || last_data !== 9'h010) begin errors++; $display("[TB] FAIL basic_word: got %h/%h expected 06/010", last_addr, last_data); end
        r_rd_addr = R_POWER;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h010) begin errors++; $display("[TB] FAIL basic_readback: got %h expected 010", w_rd_data); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_stop: got %0b expected 0", w_busy); end
        checks++; if (abort_cnt - ba !== 0) begin errors++; $display("[TB] FAIL basic_abort: got %0d expected 0", abort_cnt - ba); end
    endtask

    task automatic test_back_to_back();
        int   bv;
        int   ba;
        logic a0, a1, a2, a3, a4, a5;
        bv = valid_cnt;
        ba = abort_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h12, a1);
        send_byte(8'h01, a2);
        checks++; if (valid_cnt - bv !== 1 || last_addr !== 7'h09 || last_data !== 9'h001) begin errors++; $display("[TB] FAIL b2b_first: got n=%0d %h/%h expected n=1 09/001", valid_cnt - bv, last_addr, last_data); end
        bus_start();
        checks++; if (w_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %0b expected 1", w_busy); end
        send_byte(8'h34, a3);
        send_byte(8'h10, a4);
        send_byte(8'h34, a5);
        bus_stop();
        checks++; if ({a0, a1, a2, a3, a4, a5} !== 6'b111111) begin errors++; $display("[TB] FAIL b2b_acks: got %b expected 111111", {a0, a1, a2, a3, a4, a5}); end
        checks++; if (valid_cnt - bv !== 2 || last_addr !== 7'h08 || last_data !== 9'h034) begin errors++; $display("[TB] FAIL b2b_second: got n=%0d %h/%h expected n=2 08/034", valid_cnt - bv, last_addr, last_data); end
        checks++; if (abort_cnt - ba !== 0) begin errors++; $display("[TB] FAIL b2b_abort: got %0d expected 0", abort_cnt - ba); end
        r_rd_addr = R_ACTIVE;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h001) begin errors++; $display("[TB] FAIL b2b_rd9: got %h expected 001", w_rd_data); end
        r_rd_addr = R_SRATE;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h034) begin errors++; $display("[TB] FAIL b2b_rd8: got %h expected 034", w_rd_data); end
    endtask

    task automatic test_wrong_address();
        logic [7:0] addrs [2];
        int   bv;
        int   bl;
        logic a0, a1;
        addrs[0] = 8'h36;
        addrs[1] = 8'h35;
        for (int i = 0; i < 2; i++) begin
            bv = valid_cnt;
            bl = dut_low_cnt;
            bus_start();
            send_byte(addrs[i], a0);
            send_byte(8'h00, a1);
            bus_stop();
            checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("[TB] FAIL wrong_addr_ack byte=%h: got %b expected 00", addrs[i], {a0, a1}); end
            checks++; if (dut_low_cnt - bl !== 0) begin errors++; $display("[TB] FAIL wrong_addr_sda byte=%h: got %0d low cycles expected 0", addrs[i], dut_low_cnt - bl); end
            checks++; if (valid_cnt - bv !== 0) begin errors++; $display("[TB] FAIL wrong_addr_valid byte=%h: got %0d expected 0", addrs[i], valid_cnt - bv); end
        end
    endtask

    task automatic test_abort();
        int   bv;
        int   ba;
        logic a0, a1;
        bv = valid_cnt;
        ba = abort_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h04, a1);
        bus_stop();
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("[TB] FAIL abort_acks: got %b expected 11", {a0, a1}); end
        checks++; if (abort_cnt - ba !== 1) begin errors++; $display("[TB] FAIL abort_pulse: got %0d expected 1", abort_cnt - ba); end
        checks++; if (valid_cnt - bv !== 0) begin errors++; $display("[TB] FAIL abort_valid: got %0d expected 0", valid_cnt - bv); end
        r_rd_addr = R_LOUT;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h000) begin errors++; $display("[TB] FAIL abort_rd2: got %h expected 000", w_rd_data); end
        r_rd_addr = R_POWER;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h010) begin errors++; $display("[TB] FAIL abort_rd6: got %h expected 010", w_rd_data); end
    endtask

    task automatic test_extra_bytes();
        int   bv;
        int   ba;
        logic a0, a1, a2, a3;
        bv = valid_cnt;
        ba = abort_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h04, a1);
        send_byte(8'h79, a2);
        send_byte(8'hAA, a3);
        bus_stop();
        checks++; if ({a0, a1, a2, a3} !== 4'b1110) begin errors++; $display("[TB] FAIL extra_acks: got %b expected 1110", {a0, a1, a2, a3}); end
        checks++; if (valid_cnt - bv !== 1 || last_addr !== 7'h02 || last_data !== 9'h079) begin errors++; $display("[TB] FAIL extra_word: got n=%0d %h/%h expected n=1 02/079", valid_cnt - bv, last_addr, last_data); end
        checks++; if (abort_cnt - ba !== 0) begin errors++; $display("[TB] FAIL extra_abort: got %0d expected 0", abort_cnt - ba); end
        r_rd_addr = R_LOUT;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h079) begin errors++; $display("[TB] FAIL extra_rd2: got %h expected 079", w_rd_data); end
    endtask

    task automatic test_index_bounds();
        int   bv;
        logic a0, a1, a2, a3, a4, a5;
        bv = valid_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h25, a1);
        send_byte(8'h80, a2);
        checks++; if (last_addr !== 7'h12 || last_data !== 9'h180) begin errors++; $display("[TB] FAIL bounds_last_reg_word: got %h/%h expected 12/180", last_addr, last_data); end
        bus_start();
        send_byte(8'h34, a3);
        send_byte(8'h27, a4);
        send_byte(8'h11, a5);
        bus_stop();
        checks++; if ({a0, a1, a2, a3, a4, a5} !== 6'b111111) begin errors++; $display("[TB] FAIL bounds_acks: got %b expected 111111", {a0, a1, a2, a3, a4, a5}); end
        checks++; if (valid_cnt - bv !== 2 || last_addr !== 7'h13 || last_data !== 9'h111) begin errors++; $display("[TB] FAIL bounds_oob_word: got n=%0d %h/%h expected n=2 13/111", valid_cnt - bv, last_addr, last_data); end
        r_rd_addr = 7'h12;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h180) begin errors++; $display("[TB] FAIL bounds_rd12: got %h expected 180", w_rd_data); end
        r_rd_addr = 7'h13;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h000) begin errors++; $display("[TB] FAIL bounds_rd13: got %h expected 000", w_rd_data); end
        r_rd_addr = 7'h7F;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h000) begin errors++; $display("[TB] FAIL bounds_rd7f: got %h expected 000", w_rd_data); end
    endtask

    task automatic test_reset_mid_ack();
        int   bv;
        int   bad;
        logic a0, a1, a2, a3;
        bus_start();
        send_byte(8'h34, a0);
        send_bits(8'h0C);
        r_m_low = 1'b0;
        @(negedge clk);
        checks++; if (a0 !== 1'b1 || w_sda !== 1'b0) begin errors++; $display("[TB] FAIL midack_driving: got ack=%b sda=%b expected 1/0", a0, w_sda); end
        rst_n = 1'b0;
        #1;
        checks++; if (w_sda !== 1'b1) begin errors++; $display("[TB] FAIL midack_release: got %b expected 1", w_sda); end
        r_m_scl = 1'b1;
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i <= 18; i++) begin
            r_rd_addr = 7'(i);
            #1;
            if (w_rd_data !== 9'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL midack_regfile_cleared: got %0d nonzero entries expected 0", bad); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("[TB] FAIL midack_busy: got %0b expected 0", w_busy); end
        rst_n = 1'b1;
        wait_q();
        bv = valid_cnt;
        bus_start();
        send_byte(8'h34, a1);
        send_byte(8'h0E, a2);
        send_byte(8'h5A, a3);
        bus_stop();
        checks++; if ({a1, a2, a3} !== 3'b111) begin errors++; $display("[TB] FAIL post_reset_acks: got %b expected 111", {a1, a2, a3}); end
        checks++; if (valid_cnt - bv !== 1 || last_addr !== 7'h07 || last_data !== 9'h05A) begin errors++; $display("[TB] FAIL post_reset_word: got n=%0d %h/%h expected n=1 07/05a", valid_cnt - bv, last_addr, last_data); end
        r_rd_addr = R_DAIF;
        @(negedge clk);
        checks++; if (w_rd_data !== 9'h05A) begin errors++; $display("[TB] FAIL post_reset_rd7: got %h expected 05a", w_rd_data); end
    endtask

    // Run each scenario in order, then report the tally.
    initial begin
        test_reset();
        test_basic_write();
        test_back_to_back();
        test_wrong_address();
        test_abort();
        test_extra_bytes();
        test_index_bounds();
        test_reset_mid_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
